// File: rtl/dct8_chen_ts_pkg.sv
// Shared widths, state/schedule types, cosine constants and the 22-step MAC schedule
// for the time-shared 8-point Chen DCT. Saturation is selected by DCT8_CHEN_TS_SAT_EN.
package dct8_chen_ts_pkg;

    localparam int unsigned IN_W    = 32;
    localparam int unsigned CONST_W = 12;
    localparam int unsigned FRAC    = 8;
    localparam int unsigned BF_W    = IN_W + 2;
    localparam int unsigned OP_W    = IN_W + 3;   // c0+c1 / c0-c1 need one bit above the butterfly
    localparam int unsigned PROD_W  = OP_W + CONST_W;
    localparam int unsigned ACC_W   = PROD_W + 3;
    localparam int unsigned N_STEPS = 22;
    localparam int unsigned STEP_W  = 5;
    localparam int unsigned IDX_W   = 3;

    typedef enum logic [1:0] {IDLE, BFLY, MAC, DONE} state_e;

    typedef enum logic [2:0] {
        OP_C0P1, OP_C0M1, OP_C2, OP_C3, OP_B0, OP_B1, OP_B2, OP_B3
    } opsel_e;

    typedef struct packed {
        opsel_e           opsel;
        logic [IDX_W-1:0] cidx;
        logic             sub;
        logic             last;
        logic [IDX_W-1:0] oidx;
    } sched_t;

    typedef logic [7:0][CONST_W-1:0] coef_tbl_t;

    // Ck = round(0.5*cos(k*pi/16)*2^FRAC), derived from Q30 cosines with integer math only.
    function automatic coef_tbl_t coef_table();
        coef_tbl_t t;
        longint    q;
        longint    v;
        t = '0;
        for (int k = 0; k < 8; k++) begin
            case (k)
                1:       q = 64'sd1053110176;
                2:       q = 64'sd992008094;
                3:       q = 64'sd892783698;
                4:       q = 64'sd759250125;
                5:       q = 64'sd596538995;
                6:       q = 64'sd410903207;
                7:       q = 64'sd209476638;
                default: q = 64'sd1073741824;
            endcase
            v    = (q <<< FRAC) + (64'sd1 <<< 30);
            t[k] = CONST_W'(v >>> 31);
        end
        return t;
    endfunction

    localparam coef_tbl_t COEF_TBL = coef_table();

    function automatic sched_t sched_rom(input logic [STEP_W-1:0] s);
        sched_t e;
        case (s)
            5'd0:    e = '{OP_C0P1, 3'd4, 1'b0, 1'b1, 3'd0};
            5'd1:    e = '{OP_C0M1, 3'd4, 1'b0, 1'b1, 3'd4};
            5'd2:    e = '{OP_C3,   3'd2, 1'b0, 1'b0, 3'd2};
            5'd3:    e = '{OP_C2,   3'd6, 1'b0, 1'b1, 3'd2};
            5'd4:    e = '{OP_C3,   3'd6, 1'b0, 1'b0, 3'd6};
            5'd5:    e = '{OP_C2,   3'd2, 1'b1, 1'b1, 3'd6};
            5'd6:    e = '{OP_B0,   3'd1, 1'b0, 1'b0, 3'd1};
            5'd7:    e = '{OP_B1,   3'd3, 1'b0, 1'b0, 3'd1};
            5'd8:    e = '{OP_B2,   3'd5, 1'b0, 1'b0, 3'd1};
            5'd9:    e = '{OP_B3,   3'd7, 1'b0, 1'b1, 3'd1};
            5'd10:   e = '{OP_B0,   3'd3, 1'b0, 1'b0, 3'd3};
            5'd11:   e = '{OP_B1,   3'd7, 1'b1, 1'b0, 3'd3};
            5'd12:   e = '{OP_B2,   3'd1, 1'b1, 1'b0, 3'd3};
            5'd13:   e = '{OP_B3,   3'd5, 1'b1, 1'b1, 3'd3};
            5'd14:   e = '{OP_B0,   3'd5, 1'b0, 1'b0, 3'd5};
            5'd15:   e = '{OP_B1,   3'd1, 1'b1, 1'b0, 3'd5};
            5'd16:   e = '{OP_B2,   3'd7, 1'b0, 1'b0, 3'd5};
            5'd17:   e = '{OP_B3,   3'd3, 1'b0, 1'b1, 3'd5};
            5'd18:   e = '{OP_B0,   3'd7, 1'b0, 1'b0, 3'd7};
            5'd19:   e = '{OP_B1,   3'd5, 1'b1, 1'b0, 3'd7};
            5'd20:   e = '{OP_B2,   3'd3, 1'b0, 1'b0, 3'd7};
            5'd21:   e = '{OP_B3,   3'd1, 1'b1, 1'b1, 3'd7};
            default: e = '{OP_C0P1, 3'd0, 1'b0, 1'b0, 3'd0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/dct8_chen_ts_mac.sv
// Pipelined multiply, accumulate, round/shift and narrowing for one DCT coefficient term.
// DCT8_CHEN_TS_SAT_EN defined: saturate to IN_W; undefined: two's-complement wrap.
module dct8_chen_ts_mac
    import dct8_chen_ts_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      issue_i,
    input  logic signed [OP_W-1:0]    opnd_i,
    input  logic signed [CONST_W-1:0] coef_i,
    input  logic                      sub_i,
    input  logic                      last_i,
    input  logic [IDX_W-1:0]          oidx_i,
    output logic                      res_valid_c_o,
    output logic [IDX_W-1:0]          res_idx_c_o,
    output logic signed [IN_W-1:0]    res_c_o
);

    localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) <<< (FRAC - 1);

    logic signed [PROD_W-1:0] prod_q;
    logic                     vld_q;
    logic                     sub_q;
    logic                     last_q;
    logic [IDX_W-1:0]         oidx_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  term;

    // Product register, then accumulate; the accumulator clears after each coefficient's last term.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prod_q <= '0;
            vld_q  <= 1'b0;
            sub_q  <= 1'b0;
            last_q <= 1'b0;
            oidx_q <= '0;
            acc_q  <= '0;
        end else begin
            vld_q <= issue_i;
            if (issue_i) begin
                prod_q <= PROD_W'(opnd_i) * PROD_W'(coef_i);
                sub_q  <= sub_i;
                last_q <= last_i;
                oidx_q <= oidx_i;
            end
            if (vld_q) begin
                acc_q <= last_q ? '0 : acc_d;
            end
        end
    end

    always_comb begin
        term  = ACC_W'(prod_q);
        acc_d = sub_q ? (acc_q - term) : (acc_q + term);
    end

    assign res_valid_c_o = vld_q & last_q;
    assign res_idx_c_o   = oidx_q;

`ifdef DCT8_CHEN_TS_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (IN_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (IN_W - 1)));

    logic signed [ACC_W-1:0] scaled;

    always_comb begin
        scaled = (acc_d + RND_HALF) >>> FRAC;
        if (scaled > SAT_MAX) begin
            res_c_o = IN_W'(SAT_MAX);
        end else if (scaled < SAT_MIN) begin
            res_c_o = IN_W'(SAT_MIN);
        end else begin
            res_c_o = IN_W'(scaled);
        end
    end
`else
    assign res_c_o = IN_W'((acc_d + RND_HALF) >>> FRAC);
`endif

endmodule

// File: rtl/dct8_chen_time_shared.sv
// 8-point forward DCT-II (Chen factorisation) on one time-shared MAC, 22 products per vector.
// Output saturation is enabled by defining DCT8_CHEN_TS_SAT_EN (wrap otherwise).
module dct8_chen_time_shared
    import dct8_chen_ts_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic signed [IN_W-1:0] in0,
    input  logic signed [IN_W-1:0] in1,
    input  logic signed [IN_W-1:0] in2,
    input  logic signed [IN_W-1:0] in3,
    input  logic signed [IN_W-1:0] in4,
    input  logic signed [IN_W-1:0] in5,
    input  logic signed [IN_W-1:0] in6,
    input  logic signed [IN_W-1:0] in7,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic signed [IN_W-1:0] out0,
    output logic signed [IN_W-1:0] out1,
    output logic signed [IN_W-1:0] out2,
    output logic signed [IN_W-1:0] out3,
    output logic signed [IN_W-1:0] out4,
    output logic signed [IN_W-1:0] out5,
    output logic signed [IN_W-1:0] out6,
    output logic signed [IN_W-1:0] out7
);

    state_e                   state_q, state_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     accept, issue, finish;
    logic signed [IN_W-1:0]   x     [8];
    logic signed [BF_W-1:0]   a_d   [4];
    logic signed [BF_W-1:0]   b_d   [4];
    logic signed [BF_W-1:0]   c_d   [4];
    logic signed [BF_W-1:0]   a_q   [4];
    logic signed [BF_W-1:0]   b_q   [4];
    logic signed [BF_W-1:0]   c_q   [4];
    logic signed [IN_W-1:0]   res_q [7];
    logic signed [IN_W-1:0]   out_q [8];
    sched_t                   ent;
    logic signed [OP_W-1:0]   opnd;
    logic signed [CONST_W-1:0] coef;
    logic                     res_valid;
    logic [IDX_W-1:0]         res_idx;
    logic signed [IN_W-1:0]   res;

    assign x = '{in0, in1, in2, in3, in4, in5, in6, in7};

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        accept  = 1'b0;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: if (in_valid && in_ready_q) begin
                accept  = 1'b1;
                state_d = BFLY;
            end
            BFLY: begin
                state_d = MAC;
                step_d  = '0;
            end
            // One extra MAC cycle drains the product register before DONE.
            MAC: if (step_q == STEP_W'(N_STEPS)) begin
                finish  = 1'b1;
                state_d = DONE;
            end else begin
                issue  = 1'b1;
                step_d = step_q + STEP_W'(1);
            end
            DONE: if (out_ready) begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            a_d[i] = BF_W'(x[i]) + BF_W'(x[7 - i]);
            b_d[i] = BF_W'(x[i]) - BF_W'(x[7 - i]);
        end
        c_d[0] = a_q[0] + a_q[3];
        c_d[1] = a_q[1] + a_q[2];
        c_d[2] = a_q[1] - a_q[2];
        c_d[3] = a_q[0] - a_q[3];
    end

    always_comb begin
        ent  = sched_rom(step_q);
        coef = signed'(COEF_TBL[ent.cidx]);
        case (ent.opsel)
            OP_C0P1: opnd = OP_W'(c_q[0]) + OP_W'(c_q[1]);
            OP_C0M1: opnd = OP_W'(c_q[0]) - OP_W'(c_q[1]);
            OP_C2:   opnd = OP_W'(c_q[2]);
            OP_C3:   opnd = OP_W'(c_q[3]);
            OP_B0:   opnd = OP_W'(b_q[0]);
            OP_B1:   opnd = OP_W'(b_q[1]);
            OP_B2:   opnd = OP_W'(b_q[2]);
            OP_B3:   opnd = OP_W'(b_q[3]);
            default: opnd = '0;
        endcase
    end

    dct8_chen_ts_mac u_mac (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .issue_i       (issue),
        .opnd_i        (opnd),
        .coef_i        (coef),
        .sub_i         (ent.sub),
        .last_i        (ent.last),
        .oidx_i        (ent.oidx),
        .res_valid_c_o (res_valid),
        .res_idx_c_o   (res_idx),
        .res_c_o       (res)
    );

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
                c_q[i] <= '0;
            end
            for (int i = 0; i < 7; i++) res_q[i] <= '0;
            for (int i = 0; i < 8; i++) out_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            in_ready_q  <= (state_d == IDLE);
            out_valid_q <= (state_d == DONE);
            if (accept) begin
                a_q <= a_d;
                b_q <= b_d;
            end
            if (state_q == BFLY) c_q <= c_d;
            // X0..X6 are staged so the visible outputs change only on entry to DONE.
            if (res_valid && (res_idx != IDX_W'(7))) res_q[res_idx] <= res;
            if (finish) begin
                for (int i = 0; i < 7; i++) out_q[i] <= res_q[i];
                out_q[7] <= res;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];
    assign out4 = out_q[4];
    assign out5 = out_q[5];
    assign out6 = out_q[6];
    assign out7 = out_q[7];

endmodule

// File: tb/tb_dct8_chen_time_shared.sv
// Directed, table-driven bench for dct8_chen_time_shared; expectations follow DCT8_CHEN_TS_SAT_EN.
module tb_dct8_chen_time_shared;

    typedef logic [7:0][31:0] v8_t;
    typedef struct {
        string name;
        v8_t   x;
        v8_t   e;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic signed [31:0] in0, in1, in2, in3, in4, in5, in6, in7;
    logic signed [31:0] out0, out1, out2, out3, out4, out5, out6, out7;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl [8];

    always #5 clk = ~clk;

    dct8_chen_time_shared dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in5(in5), .in6(in6), .in7(in7),
        .out_valid(out_valid), .out_ready(out_ready),
        .out0(out0), .out1(out1), .out2(out2), .out3(out3),
        .out4(out4), .out5(out5), .out6(out6), .out7(out7)
    );

    function automatic v8_t v8(input int a0, input int a1, input int a2, input int a3,
                               input int a4, input int a5, input int a6, input int a7);
        v8_t r;
        r[0] = 32'(a0); r[1] = 32'(a1); r[2] = 32'(a2); r[3] = 32'(a3);
        r[4] = 32'(a4); r[5] = 32'(a5); r[6] = 32'(a6); r[7] = 32'(a7);
        return r;
    endfunction

    function automatic v8_t outs();
        v8_t r;
        r[0] = out0; r[1] = out1; r[2] = out2; r[3] = out3;
        r[4] = out4; r[5] = out5; r[6] = out6; r[7] = out7;
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_outs(input string tag, input v8_t e);
        v8_t g;
        g = outs();
        for (int k = 0; k < 8; k++) check($sformatf("%s X%0d", tag, k), g[k], e[k]);
    endtask

    task automatic drive(input v8_t x);
        in0 = x[0]; in1 = x[1]; in2 = x[2]; in3 = x[3];
        in4 = x[4]; in5 = x[5]; in6 = x[6]; in7 = x[7];
    endtask

    // Present one vector, return edges from acceptance to out_valid (capped at 100).
    task automatic send(input string tag, input v8_t x, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, " in_ready wait"}, 32'(in_ready), 32'd1);
        drive(x);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;

        tbl[0] = '{"dc100",  v8(100, 100, 100, 100, 100, 100, 100, 100), v8(284, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1] = '{"imp0p",  v8(256, 0, 0, 0, 0, 0, 0, 0), v8(91, 126, 118, 106, 91, 71, 49, 25)};
        tbl[2] = '{"imp0n",  v8(-256, 0, 0, 0, 0, 0, 0, 0), v8(-91, -126, -118, -106, -91, -71, -49, -25)};
        tbl[3] = '{"imp1",   v8(0, 256, 0, 0, 0, 0, 0, 0), v8(91, 106, 49, -25, -91, -126, -118, -71)};
        tbl[4] = '{"imp2",   v8(0, 0, 256, 0, 0, 0, 0, 0), v8(91, 71, -49, -126, -91, 25, 118, 106)};
        tbl[5] = '{"imp3",   v8(0, 0, 0, 256, 0, 0, 0, 0), v8(91, 25, -118, -71, 91, 106, -49, -126)};
        tbl[6] = '{"imp7",   v8(0, 0, 0, 0, 0, 0, 0, 256), v8(91, -126, 118, -106, 91, -71, 49, -25)};
`ifdef DCT8_CHEN_TS_SAT_EN
        tbl[7] = '{"maxpos", {8{32'h7FFF_FFFF}}, v8(2147483647, 0, 0, 0, 0, 0, 0, 0)};
`else
        tbl[7] = '{"maxpos", {8{32'h7FFF_FFFF}}, v8(1811939325, 0, 0, 0, 0, 0, 0, 0)};
`endif

        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive('0);
        repeat (3) @(negedge clk);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd0);
        check_outs("reset", '0);
        rst_n = 1'b0;
        @(negedge clk);
        check("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i].name, tbl[i].x, lat);
            check({tbl[i].name, " latency"}, 32'(lat), 32'd24);
            check_outs(tbl[i].name, tbl[i].e);
            release_out(tbl[i].name);
        end

        // Back-pressure: outputs held, input blocked, extra in_valid dropped.
        send("stall", tbl[1].x, lat);
        check("stall latency", 32'(lat), 32'd24);
        for (int c = 0; c < 10; c++) begin
            drive(v8(7, 7, 7, 7, 7, 7, 7, 7));
            in_valid = 1'b1;
            @(negedge clk);
            check_outs($sformatf("stall c%0d", c), tbl[1].e);
            check($sformatf("stall c%0d in_ready", c), 32'(in_ready), 32'd0);
            check($sformatf("stall c%0d out_valid", c), 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        release_out("stall");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall idle c%0d in_ready", c), 32'(in_ready), 32'd1);
            check($sformatf("stall idle c%0d out_valid", c), 32'(out_valid), 32'd0);
        end

        // Reset 10 cycles into MAC aborts the vector and clears the outputs.
        drive(tbl[0].x);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        check("midmac out_valid pre", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        #1;
        check("midmac out_valid", 32'(out_valid), 32'd0);
        check("midmac in_ready", 32'(in_ready), 32'd0);
        check_outs("midmac", '0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midmac in_ready after", 32'(in_ready), 32'd1);
        send("after_rst", tbl[0].x, lat);
        check("after_rst latency", 32'(lat), 32'd24);
        check_outs("after_rst", tbl[0].e);
        release_out("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
